// File: rtl/trg_pls_pkg.sv
// Shared types and constants for the SPI-driven trigger pulse generator.
package trg_pls_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned NCH        = 5;
  localparam int unsigned CMD_W      = 3;
  localparam int unsigned MASK_W     = 5;
  localparam int unsigned WIDTH_W    = 8;
  localparam int unsigned BCNT_W     = $clog2(FRAME_BITS + 2);

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP      = 3'd0,
    CMD_PULSE    = 3'd1,
    CMD_LEVEL_ON = 3'd2,
    CMD_CLEAR    = 3'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_LEVEL = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [CMD_W-1:0]   cmd;
    logic [MASK_W-1:0]  mask;
    logic [WIDTH_W-1:0] width;
  } frame_t;

  // Encodings 4..7 are reserved.
  function automatic logic cmd_valid(input logic [CMD_W-1:0] c);
    return !c[CMD_W-1];
  endfunction

endpackage

// File: rtl/trg_pls_channel.sv
// One trigger channel: IDLE/PULSE/LEVEL state machine with a pulse down-counter.
module trg_pls_channel
  import trg_pls_pkg::*;
#(
  parameter int unsigned CW = 14
) (
  input  logic          clk_50,
  input  logic          reset_n,
  input  cmd_e          cmd_i,
  input  logic          sel_i,
  input  logic          commit_i,
  input  logic [CW-1:0] load_val_i,
  output logic          trg_o,
  output logic          active_o
);

  ch_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trg_q, active_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    if (state_q == ST_PULSE) begin
      if (cnt_q <= CW'(1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    // A command on the same cycle as terminal count overrides the countdown.
    if (commit_i && sel_i) begin
      case (cmd_i)
        CMD_PULSE: begin
          if ((load_val_i != '0) && (state_q != ST_LEVEL)) begin
            state_d = ST_PULSE;
            cnt_d   = load_val_i;
          end
        end
        CMD_LEVEL_ON: begin
          state_d = ST_LEVEL;
          cnt_d   = '0;
        end
        CMD_CLEAR: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      trg_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      trg_q    <= (state_d != ST_IDLE);
      active_q <= (state_d == ST_PULSE);
    end
  end

  assign trg_o    = trg_q;
  assign active_o = active_q;

endmodule

// File: rtl/trg_pls_spi_rx.sv
// SPI-slave frame receiver driving NCH trigger channels (pulses or static levels).
module trg_pls_spi_rx #(
  parameter int unsigned PRESCALE = 50,
  parameter int unsigned NCH      = 5
) (
  input  logic           clk_50,
  input  logic           reset_n,
  input  logic           spi_clk,
  input  logic           spi_cs,
  input  logic           spi_mosi,
  output logic [NCH-1:0] trg,
  output logic           busy,
  output logic           frame_err
);

  import trg_pls_pkg::*;

  localparam int unsigned CW = $clog2(255 * PRESCALE + 1);

  logic [1:0] clk_sync_q, cs_sync_q, mosi_sync_q;
  logic       clk_dly_q, cs_dly_q;
  logic       clk_s, cs_s, mosi_s;
  logic       clk_rise, cs_rise, cs_fall;

  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic                  armed_q, armed_d;
  logic                  commit_q, commit_d;
  logic                  ferr_q, ferr_d;

  frame_t        frm;
  cmd_e          cmd_c;
  logic [CW-1:0] load_val_c;
  logic [NCH-1:0] ch_trg, ch_active;

  // 2-FF synchronisers plus one delay stage for edge detection.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      clk_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      clk_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], spi_clk};
      cs_sync_q   <= {cs_sync_q[0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      clk_dly_q   <= clk_sync_q[1];
      cs_dly_q    <= cs_sync_q[1];
    end
  end

  assign clk_s    = clk_sync_q[1];
  assign cs_s     = cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign clk_rise = clk_s & ~clk_dly_q;
  assign cs_rise  = cs_s & ~cs_dly_q;
  assign cs_fall  = ~cs_s & cs_dly_q;

  always_comb begin
    shift_d  = shift_q;
    bcnt_d   = bcnt_q;
    armed_d  = armed_q | cs_s;
    commit_d = 1'b0;
    ferr_d   = 1'b0;

    if (cs_fall) begin
      bcnt_d = '0;
    end else if (!cs_s && clk_rise) begin
      shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
      if (bcnt_q != BCNT_W'(FRAME_BITS + 1)) begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end

    // Disarmed: a frame already in flight at reset release is dropped silently.
    if (cs_rise && armed_q) begin
      if ((bcnt_q == BCNT_W'(FRAME_BITS)) && cmd_valid(frm.cmd)) begin
        commit_d = 1'b1;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      shift_q  <= '0;
      bcnt_q   <= '0;
      armed_q  <= 1'b0;
      commit_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bcnt_q   <= bcnt_d;
      armed_q  <= armed_d;
      commit_q <= commit_d;
      ferr_q   <= ferr_d;
    end
  end

  // Shifter is stable while spi_cs is high, so it is decoded directly at commit.
  assign frm        = frame_t'(shift_q);
  assign cmd_c      = cmd_e'(frm.cmd);
  assign load_val_c = CW'(frm.width) * CW'(PRESCALE);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    trg_pls_channel #(
      .CW(CW)
    ) u_ch (
      .clk_50    (clk_50),
      .reset_n   (reset_n),
      .cmd_i     (cmd_c),
      .sel_i     (frm.mask[i]),
      .commit_i  (commit_q),
      .load_val_i(load_val_c),
      .trg_o     (ch_trg[i]),
      .active_o  (ch_active[i])
    );
  end

  assign trg       = ch_trg;
  assign busy      = |ch_active;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_trg_pls_spi_rx.sv
// Randomised and directed bench for trg_pls_spi_rx with a per-cycle behavioural model.
module tb_trg_pls_spi_rx;

  localparam int PRESC = 50;

  logic       clk_50   = 1'b0;
  logic       reset_n  = 1'b0;
  logic       spi_clk  = 1'b0;
  logic       spi_cs   = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [4:0] trg;
  logic       busy;
  logic       frame_err;

  trg_pls_spi_rx #(.PRESCALE(PRESC), .NCH(5)) dut (
    .clk_50   (clk_50),
    .reset_n  (reset_n),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi),
    .trg      (trg),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #10 clk_50 = ~clk_50;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int          apply_cyc;
    logic [15:0] frame;
    bit          ok;
  } ev_t;
  ev_t evq[$];

  // Model: mode 0 idle, 1 pulsing (rem cycles left), 2 static level.
  int         mode[5];
  int         rem[5];
  logic [4:0] exp_trg  = '0;
  logic       exp_busy = 1'b0;
  logic       exp_ferr = 1'b0;

  int all_hi = 0, busy_hi = 0, ferr_n = 0, run2 = 0, last_run2 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk_50) begin
    ev_t  e;
    int   cmd, w;
    cyc++;
    exp_ferr = 1'b0;
    if (!reset_n) begin
      for (int c = 0; c < 5; c++) begin
        mode[c] = 0;
        rem[c]  = 0;
      end
      evq.delete();
    end else begin
      for (int c = 0; c < 5; c++) begin
        if (mode[c] == 1) begin
          rem[c]--;
          if (rem[c] == 0) mode[c] = 0;
        end
      end
      if (evq.size() > 0) begin
        e   = evq[0];
        cmd = int'(e.frame[15:13]);
        w   = int'(e.frame[7:0]);
        if ((e.apply_cyc - 1 == cyc) && (!e.ok || cmd > 3)) exp_ferr = 1'b1;
        if (e.apply_cyc == cyc) begin
          if (e.ok && cmd <= 3) begin
            for (int c = 0; c < 5; c++) begin
              if (e.frame[8+c]) begin
                case (cmd)
                  1: if (w != 0 && mode[c] != 2) begin mode[c] = 1; rem[c] = w * PRESC; end
                  2: begin mode[c] = 2; rem[c] = 0; end
                  3: begin mode[c] = 0; rem[c] = 0; end
                  default: ;
                endcase
              end
            end
          end
          void'(evq.pop_front());
        end
      end
    end
    exp_busy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      exp_trg[c] = (mode[c] != 0);
      if (mode[c] == 1) exp_busy = 1'b1;
    end
  end

  always @(negedge clk_50) begin
    if (chk_en) begin
      chk("trg", 32'(trg), 32'(exp_trg));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("frame_err", 32'(frame_err), 32'(exp_ferr));
    end
  end

  always @(negedge clk_50) begin
    if (trg === 5'h1F) all_hi++;
    if (busy === 1'b1) busy_hi++;
    if (frame_err === 1'b1) ferr_n++;
    if (trg[2] === 1'b1) run2++;
    else begin
      if (run2 > 0) last_run2 = run2;
      run2 = 0;
    end
  end

  // Sends nbits of f MSB first; optional cs-rise cycle and mid-frame reset.
  task automatic send_frame(input logic [15:0] f, input int nbits, input int hp,
                            input int rise_at, input int rst_bit, output int p);
    spi_cs = 1'b0;
    repeat (hp) @(negedge clk_50);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        reset_n = 1'b0;
        @(negedge clk_50);
        chk("trg_in_reset", 32'(trg), 32'd0);
        chk("busy_in_reset", 32'(busy), 32'd0);
        repeat (2) @(negedge clk_50);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_50);
      end
      spi_mosi = (i < 16) ? f[15-i] : 1'b0;
      repeat (hp) @(negedge clk_50);
      spi_clk = 1'b1;
      repeat (hp) @(negedge clk_50);
      spi_clk = 1'b0;
    end
    repeat (hp) @(negedge clk_50);
    while (rise_at > 0 && cyc < rise_at) @(negedge clk_50);
    spi_cs = 1'b1;
    p = cyc;
    if (rst_bit < 0) evq.push_back('{p + 4, f, (nbits == 16)});
    repeat (6) @(negedge clk_50);
  endtask

  initial begin
    int p1, p2, a0, b0, f0;
    logic [15:0] f;
    int r, nb;

    repeat (2) @(negedge clk_50);
    chk_en = 1'b1;
    chk("reset_trg", 32'(trg), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ferr", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    repeat (8) @(negedge clk_50);

    a0 = all_hi; b0 = busy_hi; f0 = ferr_n;
    send_frame(16'h3F0A, 16, 4, 0, -1, p1);
    repeat (600) @(negedge clk_50);
    chk("pulse_all_width", 32'(all_hi - a0), 32'd500);
    chk("pulse_busy_width", 32'(busy_hi - b0), 32'd500);
    chk("pulse_no_ferr", 32'(ferr_n - f0), 32'd0);

    send_frame(16'h4301, 16, 4, 0, -1, p1);
    repeat (20) @(negedge clk_50);
    chk("level_on", 32'(trg), 32'h03);
    repeat (200) @(negedge clk_50);
    chk("level_hold", 32'(trg), 32'h03);
    send_frame(16'h6100, 16, 4, 0, -1, p1);
    repeat (10) @(negedge clk_50);
    chk("clear_ch0", 32'(trg), 32'h02);

    send_frame(16'h2404, 16, 3, 0, -1, p1);
    send_frame(16'h2404, 16, 3, p1 + 120, -1, p2);
    repeat (400) @(negedge clk_50);
    chk("retrigger_run", 32'(last_run2), 32'd320);
    send_frame(16'h2404, 16, 3, 0, -1, p1);
    send_frame(16'h2404, 16, 3, p1 + 200, -1, p2);
    repeat (500) @(negedge clk_50);
    chk("retrigger_last_cycle_run", 32'(last_run2), 32'd400);

    f0 = ferr_n;
    send_frame(16'h2102, 15, 4, 0, -1, p1);
    send_frame(16'h2102, 17, 4, 0, -1, p1);
    repeat (10) @(negedge clk_50);
    chk("bad_len_ferr", 32'(ferr_n - f0), 32'd2);
    chk("bad_len_trg", 32'(trg), 32'h02);
    f0 = ferr_n;
    send_frame(16'hE0FF, 16, 4, 0, -1, p1);
    repeat (10) @(negedge clk_50);
    chk("reserved_ferr", 32'(ferr_n - f0), 32'd1);
    chk("reserved_trg", 32'(trg), 32'h02);

    send_frame(16'h2100, 16, 4, 0, -1, p1);
    send_frame(16'h2205, 16, 4, 0, -1, p1);
    repeat (10) @(negedge clk_50);
    chk("w0_and_level_ignore", 32'(trg), 32'h02);

    send_frame(16'h24FF, 16, 4, 0, -1, p1);
    repeat (12800) @(negedge clk_50);
    chk("max_width_run", 32'(last_run2), 32'd12750);

    send_frame(16'h2414, 16, 4, 0, -1, p1);
    repeat (50) @(negedge clk_50);
    send_frame(16'h3F05, 16, 4, 0, 8, p1);
    repeat (20) @(negedge clk_50);
    chk("after_reset_trg", 32'(trg), 32'h00);
    send_frame(16'h4400, 16, 4, 0, -1, p1);
    repeat (10) @(negedge clk_50);
    chk("post_reset_frame", 32'(trg), 32'h04);

    for (int k = 0; k < 25; k++) begin
      f = 16'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 3)      f[15:13] = 3'd1;
      else if (r < 5) f[15:13] = 3'd2;
      else if (r < 7) f[15:13] = 3'd3;
      else if (r < 8) f[15:13] = 3'd0;
      else            f[15:13] = 3'($urandom_range(4, 7));
      f[7:0] = 8'($urandom_range(0, 12));
      nb = 16;
      if ($urandom_range(0, 9) == 0) nb = ($urandom_range(0, 1) == 1) ? 15 : 17;
      send_frame(f, nb, int'($urandom_range(3, 5)), 0, -1, p1);
      repeat ($urandom_range(0, 300)) @(negedge clk_50);
    end
    repeat (700) @(negedge clk_50);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
